// File: rtl/dfr_core.sv
// dfr_core: delayed-feedback reservoir accelerator behind an AXI4-Lite slave.
// Define DFR_DEBUG_EN to expose FSM state and step counter on the DEBUG register.
module dfr_core #(
    parameter int unsigned C_S_AXI_ACLK_FREQ_HZ         = 100000000,
    parameter int unsigned C_S_AXI_DATA_WIDTH           = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH           = 16,
    parameter int unsigned VIRTUAL_NODES                = 100,
    parameter int unsigned RESERVOIR_DATA_WIDTH         = 32,
    parameter int unsigned RESERVOIR_HISTORY_ADDR_WIDTH = 16
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic [31:0]                   S_AXI_WDATA,
    input  logic [3:0]                    S_AXI_WSTRB,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    output logic [1:0]                    S_AXI_BRESP,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    output logic [31:0]                   S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY,
    output logic                          busy
);

    localparam int unsigned AW   = C_S_AXI_ADDR_WIDTH;
    localparam int unsigned DW   = RESERVOIR_DATA_WIDTH;
    localparam int unsigned HA   = RESERVOIR_HISTORY_ADDR_WIDTH;
    localparam int unsigned HD   = 1 << HA;
    localparam int unsigned VN   = VIRTUAL_NODES;
    localparam int unsigned WA   = (VN > 1) ? $clog2(VN) : 1;
    localparam int unsigned NREG = 9;
    localparam logic [31:0] CTRL_MASK = 32'h0000_FF30;

    typedef enum logic [3:0] {S_IDLE, S_INIT, S_TRAIN, S_TEST, S_MAC, S_STORE} state_e;

    logic unused_c;
    assign unused_c = ^{S_AXI_WSTRB, 32'(C_S_AXI_ACLK_FREQ_HZ), 32'(C_S_AXI_DATA_WIDTH)};

    function automatic logic is_win(input logic [AW-1:0] a);
        return a[AW-1:8] == (AW-8)'(1);
    endfunction

    function automatic logic is_reg(input logic [AW-1:0] a);
        return (a < AW'(NREG * 4)) && (a[1:0] == 2'b00);
    endfunction

    // AXI channel and register-file state
    logic        aw_ready_q, aw_ready_d, b_valid_q, b_valid_d;
    logic        ar_ready_q, ar_ready_d, rd_p1_q, rd_p1_d, rd_p2_q, rd_p2_d;
    logic        r_valid_q, r_valid_d;
    logic [31:0] r_data_q, r_data_d, rdata_c, dbg_c;
    logic [AW-1:0] araddr_q, araddr_d;
    logic [31:0] cfg_q [NREG];
    logic [31:0] cfg_d [NREG];

    // Run state
    state_e      state_q, state_d;
    logic        busy_q, busy_d, ph_q, ph_d, mac_v_q, mac_v_d;
    logic [31:0] k_q, k_d, n_q, n_d, smp_q, smp_d, xptr_q, xptr_d;
    logic [31:0] end_init_q, end_init_d, end_train_q, end_train_d, end_test_q, end_test_d;
    logic [31:0] sps_q, sps_d, nsmp_q, nsmp_d;
    logic [63:0] acc_q, acc_d;

    // Memories and their read registers
    logic [DW-1:0] in_mem  [HD];
    logic [DW-1:0] res_mem [HD];
    logic [DW-1:0] w_mem   [VN];
    logic [DW-1:0] out_mem [256];
    logic [DW-1:0] in_rd, x_rd, w_rd, ram_q;

    logic          wr_hs_c, win_wr_c, start_c, fsm_res_we_c, fsm_out_we_c, res_we_c, out_we_c;
    logic [1:0]    memsel_c;
    logic [7:0]    page_c, wr_lo_c, rd_lo_c, out_waddr_c;
    logic [HA-1:0] wr_idx_c, rd_idx_c, res_waddr_c, res_raddr_c;
    logic [DW-1:0] x_old_c, x_new_c, res_wdata_c, out_wdata_c;
    logic [DW:0]   sum_c;
    logic signed [63:0] prod_c;
    logic [31:0]   phase_end_c;

    assign memsel_c = cfg_q[0][5:4];
    assign page_c   = cfg_q[0][15:8];
    assign wr_lo_c  = S_AXI_AWADDR[7:0];
    assign rd_lo_c  = araddr_q[7:0];
    assign wr_idx_c = HA'({page_c, wr_lo_c});
    assign rd_idx_c = HA'({page_c, rd_lo_c});
    assign wr_hs_c  = aw_ready_q && S_AXI_AWVALID && S_AXI_WVALID;
    assign win_wr_c = wr_hs_c && is_win(S_AXI_AWADDR) && !busy_q;
    assign start_c  = wr_hs_c && (S_AXI_AWADDR == '0) && S_AXI_WDATA[0] && (state_q == S_IDLE);

`ifdef DFR_DEBUG_EN
    assign dbg_c = {state_q, 12'b0, k_q[15:0]};
`else
    assign dbg_c = '0;
`endif

    // Register/window readback mux, evaluated one cycle after the RAM read
    always_comb begin
        rdata_c = '0;
        if (is_reg(araddr_q)) begin
            rdata_c = (araddr_q[5:2] == 4'd1) ? dbg_c : cfg_q[araddr_q[5:2]];
        end else if (is_win(araddr_q) && !busy_q) begin
            rdata_c = 32'(ram_q);
        end
    end

    // AXI handshakes and register writes
    always_comb begin
        aw_ready_d = 1'b0;
        b_valid_d  = b_valid_q;
        ar_ready_d = 1'b0;
        rd_p1_d    = 1'b0;
        rd_p2_d    = rd_p1_q;
        r_valid_d  = r_valid_q;
        r_data_d   = r_data_q;
        araddr_d   = araddr_q;
        cfg_d      = cfg_q;
        if (S_AXI_AWVALID && S_AXI_WVALID && !aw_ready_q) aw_ready_d = 1'b1;
        if (wr_hs_c) begin
            b_valid_d = 1'b1;
            if (is_reg(S_AXI_AWADDR) && S_AXI_AWADDR[5:2] != 4'd1) begin
                cfg_d[S_AXI_AWADDR[5:2]] = (S_AXI_AWADDR[5:2] == 4'd0) ?
                                           (S_AXI_WDATA & CTRL_MASK) : S_AXI_WDATA;
            end
        end else if (S_AXI_BREADY) begin
            b_valid_d = 1'b0;
        end
        if (S_AXI_ARVALID && !ar_ready_q && !r_valid_q && !rd_p1_q && !rd_p2_q) ar_ready_d = 1'b1;
        if (ar_ready_q && S_AXI_ARVALID) begin
            araddr_d = S_AXI_ARADDR;
            rd_p1_d  = 1'b1;
        end
        if (rd_p2_q) begin
            r_valid_d = 1'b1;
            r_data_d  = rdata_c;
        end else if (S_AXI_RREADY) begin
            r_valid_d = 1'b0;
        end
    end

    // Reservoir node update with saturation of the 33-bit sum
    always_comb begin
        x_old_c = (k_q < VN) ? '0 : x_rd;
        sum_c   = {in_rd[DW-1], in_rd} + {x_old_c[DW-1], x_old_c[DW-1], x_old_c[DW-1:1]};
        if (sum_c[DW] != sum_c[DW-1]) begin
            x_new_c = sum_c[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end else begin
            x_new_c = sum_c[DW-1:0];
        end
        prod_c = 64'($signed(w_rd)) * 64'($signed(x_rd));
    end

    always_comb begin
        unique case (state_q)
            S_INIT:  phase_end_c = end_init_q;
            S_TRAIN: phase_end_c = end_train_q;
            default: phase_end_c = end_test_q;
        endcase
    end

    // Run FSM: reservoir phases, then per-sample MAC and store
    always_comb begin
        state_d      = state_q;
        busy_d       = busy_q;
        ph_d         = ph_q;
        mac_v_d      = 1'b0;
        k_d          = k_q;
        n_d          = n_q;
        smp_d        = smp_q;
        xptr_d       = xptr_q;
        end_init_d   = end_init_q;
        end_train_d  = end_train_q;
        end_test_d   = end_test_q;
        sps_d        = sps_q;
        nsmp_d       = nsmp_q;
        acc_d        = acc_q;
        fsm_res_we_c = 1'b0;
        fsm_out_we_c = 1'b0;
        res_raddr_c  = HA'(k_q - VN);
        unique case (state_q)
            S_IDLE: begin
                if (start_c) begin
                    state_d     = S_INIT;
                    busy_d      = 1'b1;
                    ph_d        = 1'b0;
                    k_d         = '0;
                    n_d         = '0;
                    smp_d       = '0;
                    acc_d       = '0;
                    end_init_d  = cfg_q[6];
                    end_train_d = cfg_q[6] + cfg_q[7];
                    end_test_d  = cfg_q[6] + cfg_q[7] + cfg_q[8];
                    sps_d       = cfg_q[5];
                    nsmp_d      = cfg_q[4];
                end
            end
            S_INIT, S_TRAIN, S_TEST: begin
                if (ph_q) begin
                    fsm_res_we_c = 1'b1;
                    ph_d         = 1'b0;
                    k_d          = k_q + 32'd1;
                end else if (k_q != phase_end_c) begin
                    ph_d = 1'b1;
                end else if (state_q == S_INIT) begin
                    state_d = S_TRAIN;
                end else if (state_q == S_TRAIN) begin
                    state_d = S_TEST;
                end else begin
                    xptr_d  = end_train_q;
                    state_d = (nsmp_q == '0) ? S_IDLE : S_MAC;
                    busy_d  = (nsmp_q != '0);
                end
            end
            S_MAC: begin
                res_raddr_c = HA'(xptr_q);
                if (mac_v_q) acc_d = acc_q + prod_c;
                if (n_q == sps_q) begin
                    state_d = S_STORE;
                end else begin
                    mac_v_d = 1'b1;
                    n_d     = n_q + 32'd1;
                    xptr_d  = xptr_q + 32'd1;
                end
            end
            S_STORE: begin
                fsm_out_we_c = 1'b1;
                acc_d        = '0;
                n_d          = '0;
                smp_d        = smp_q + 32'd1;
                if (smp_q + 32'd1 == nsmp_q) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    state_d = S_MAC;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign res_we_c    = fsm_res_we_c || (win_wr_c && memsel_c == 2'd1);
    assign res_waddr_c = fsm_res_we_c ? HA'(k_q) : wr_idx_c;
    assign res_wdata_c = fsm_res_we_c ? x_new_c : DW'(S_AXI_WDATA);
    assign out_we_c    = fsm_out_we_c || (win_wr_c && memsel_c == 2'd3);
    assign out_waddr_c = fsm_out_we_c ? smp_q[7:0] : wr_lo_c;
    assign out_wdata_c = fsm_out_we_c ? DW'(acc_q[47:16]) : DW'(S_AXI_WDATA);

    // Synchronous memories: one engine read port and one AXI read port each
    always_ff @(posedge S_AXI_ACLK) begin
        if (win_wr_c && memsel_c == 2'd0) in_mem[wr_idx_c] <= DW'(S_AXI_WDATA);
        if (res_we_c) res_mem[res_waddr_c] <= res_wdata_c;
        if (win_wr_c && memsel_c == 2'd2 && {24'b0, wr_lo_c} < VN) w_mem[WA'(wr_lo_c)] <= DW'(S_AXI_WDATA);
        if (out_we_c) out_mem[out_waddr_c] <= out_wdata_c;
        in_rd <= in_mem[HA'(k_q)];
        x_rd  <= res_mem[res_raddr_c];
        w_rd  <= (n_q < VN) ? w_mem[WA'(n_q)] : '0;
        if (rd_p1_q) begin
            unique case (memsel_c)
                2'd0:    ram_q <= in_mem[rd_idx_c];
                2'd1:    ram_q <= res_mem[rd_idx_c];
                2'd2:    ram_q <= ({24'b0, rd_lo_c} < VN) ? w_mem[WA'(rd_lo_c)] : '0;
                default: ram_q <= out_mem[rd_lo_c];
            endcase
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            aw_ready_q  <= 1'b0;
            b_valid_q   <= 1'b0;
            ar_ready_q  <= 1'b0;
            rd_p1_q     <= 1'b0;
            rd_p2_q     <= 1'b0;
            r_valid_q   <= 1'b0;
            r_data_q    <= '0;
            araddr_q    <= '0;
            cfg_q       <= '{default: '0};
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            ph_q        <= 1'b0;
            mac_v_q     <= 1'b0;
            k_q         <= '0;
            n_q         <= '0;
            smp_q       <= '0;
            xptr_q      <= '0;
            end_init_q  <= '0;
            end_train_q <= '0;
            end_test_q  <= '0;
            sps_q       <= '0;
            nsmp_q      <= '0;
            acc_q       <= '0;
        end else begin
            aw_ready_q  <= aw_ready_d;
            b_valid_q   <= b_valid_d;
            ar_ready_q  <= ar_ready_d;
            rd_p1_q     <= rd_p1_d;
            rd_p2_q     <= rd_p2_d;
            r_valid_q   <= r_valid_d;
            r_data_q    <= r_data_d;
            araddr_q    <= araddr_d;
            cfg_q       <= cfg_d;
            state_q     <= state_d;
            busy_q      <= busy_d;
            ph_q        <= ph_d;
            mac_v_q     <= mac_v_d;
            k_q         <= k_d;
            n_q         <= n_d;
            smp_q       <= smp_d;
            xptr_q      <= xptr_d;
            end_init_q  <= end_init_d;
            end_train_q <= end_train_d;
            end_test_q  <= end_test_d;
            sps_q       <= sps_d;
            nsmp_q      <= nsmp_d;
            acc_q       <= acc_d;
        end
    end

    assign S_AXI_AWREADY = aw_ready_q;
    assign S_AXI_WREADY  = aw_ready_q;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_BVALID  = b_valid_q;
    assign S_AXI_ARREADY = ar_ready_q;
    assign S_AXI_RDATA   = r_data_q;
    assign S_AXI_RRESP   = 2'b00;
    assign S_AXI_RVALID  = r_valid_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_dfr_core.sv
// tb_dfr_core: AXI-Lite driven bench for dfr_core with a read-data scoreboard
// and a small reference model of the reservoir and readout.
module tb_dfr_core;

    logic        clk;
    logic        rst_n;
    logic [15:0] awaddr, araddr;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [31:0] wdata, rdata;
    logic [1:0]  bresp, rresp;
    logic        arvalid, arready, rvalid, rready, busy;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];
    logic [31:0] x_m [8];
    logic [31:0] y_m [2];

    dfr_core #(
        .VIRTUAL_NODES(4)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (4'hF),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic axi_write(input logic [15:0] a, input logic [31:0] d);
        int n = 0;
        awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
        while (!(awready && wready) && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("awready", 32'(awready && wready), 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    // Expected value is queued at request time and retired when RVALID shows up
    task automatic axi_read(input logic [15:0] a, input logic [31:0] exp, input string tag);
        int n = 0;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        araddr = a; arvalid = 1'b1;
        while (!arready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check({tag_q[0], "_rvalid"}, 32'(rvalid), 32'd1);
        check(tag_q.pop_front(), rdata, exp_q.pop_front());
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 5000) begin
            @(posedge clk); #1; n++;
        end
        check("busy_fall", 32'(busy), 32'd0);
    endtask

    task automatic run_model(input logic [31:0] inv);
        logic signed [31:0] old;
        logic signed [32:0] s;
        logic signed [63:0] acc;
        for (int k = 0; k < 8; k++) begin
            old = (k < 4) ? 32'sd0 : $signed(x_m[k-4]);
            s = 33'($signed(inv)) + 33'(old >>> 1);
            if (s > 33'sh0_7FFF_FFFF)       x_m[k] = 32'h7FFF_FFFF;
            else if (s < -33'sh0_8000_0000) x_m[k] = 32'h8000_0000;
            else                            x_m[k] = s[31:0];
        end
        for (int j = 0; j < 2; j++) begin
            acc = '0;
            for (int i = 0; i < 4; i++) acc += 64'sd65536 * 64'($signed(x_m[j*4+i]));
            y_m[j] = acc[47:16];
        end
    endtask

    task automatic load_inputs(input logic [31:0] v);
        axi_write(16'h0000, 32'h0000_0000);
        for (int k = 0; k < 8; k++) axi_write(16'h0100 + 16'(k), v);
    endtask

    task automatic run_mini(input string tag);
        axi_write(16'h0014, 32'd4);
        axi_write(16'h0018, 32'd0);
        axi_write(16'h001C, 32'd0);
        axi_write(16'h0020, 32'd8);
        axi_write(16'h0010, 32'd2);
        axi_write(16'h0000, 32'h0000_0001);
        check({tag, "_busy_rise"}, 32'(busy), 32'd1);
        wait_idle();
        axi_write(16'h0000, 32'h0000_0010);
        for (int k = 0; k < 8; k++) axi_read(16'h0100 + 16'(k), x_m[k], $sformatf("%s_x%0d", tag, k));
        axi_write(16'h0000, 32'h0000_0030);
        for (int j = 0; j < 2; j++) axi_read(16'h0100 + 16'(j), y_m[j], $sformatf("%s_y%0d", tag, j));
    endtask

    initial begin
        rst_n = 1'b0;
        awaddr = '0; wdata = '0; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        araddr = '0; arvalid = 1'b0; rready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ctrl_outs", 32'({awready, wready, bvalid, arready, rvalid, busy}), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) axi_read(16'(i * 4), 32'd0, $sformatf("rst_reg%0d", i));
        axi_write(16'h0008, 32'd100);
        axi_read(16'h0008, 32'd100, "init_samples_rb");
        axi_write(16'h0024, 32'hDEAD_BEEF);
        axi_read(16'h0024, 32'd0, "unmapped_rd");

        axi_write(16'h0000, 32'h0000_0020);
        for (int n = 0; n < 4; n++) axi_write(16'h0100 + 16'(n), 32'd65536);
        axi_write(16'h0000, 32'h0000_0020);
        axi_read(16'h0101, 32'd65536, "weight_rb");

        axi_write(16'h0020, 32'd200);
        axi_write(16'h0010, 32'd0);
        axi_write(16'h0000, 32'h0000_0021);
        check("long_busy_rise", 32'(busy), 32'd1);
        axi_read(16'h0101, 32'd0, "win_rd_busy");
        wait_idle();

        axi_write(16'h0000, 32'h0000_0000);
        axi_write(16'h0105, 32'h55);
        axi_write(16'h0000, 32'h0000_0100);
        axi_write(16'h0105, 32'd7);
        axi_write(16'h0000, 32'h0000_0000);
        axi_read(16'h0105, 32'h55, "page0_rd");
        axi_write(16'h0000, 32'h0000_0100);
        axi_read(16'h0105, 32'd7, "page1_rd");

        load_inputs(32'd65536);
        run_model(32'd65536);
        run_mini("mini");

        load_inputs(32'h7FFF_FFFF);
        run_model(32'h7FFF_FFFF);
        run_mini("sat");

        bready = 1'b0;
        axi_write(16'h0008, 32'd11);
        axi_write(16'h000C, 32'd22);
        check("bvalid_held", 32'(bvalid), 32'd1);
        bready = 1'b1;
        @(posedge clk); #1;
        check("bvalid_clr", 32'(bvalid), 32'd0);
        axi_read(16'h0008, 32'd11, "b2b_wr0");
        axi_read(16'h000C, 32'd22, "b2b_wr1");

        axi_write(16'h0020, 32'd200);
        axi_write(16'h0010, 32'd0);
        axi_write(16'h0000, 32'h0000_0001);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrun_rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        axi_read(16'h0020, 32'd0, "midrun_rst_reg");
        run_mini("after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dfr_core.md
# dfr_core

Delayed-feedback reservoir (DFR) accelerator with an AXI4-Lite slave front end. Software loads pre-masked input steps and readout weights into on-chip memories through a paged window, launches a run, waits for `busy` to fall, then reads one output per test sample. Sits on the PS–PL AXI-Lite interconnect as a self-contained compute peripheral.

## Interface
- C_S_AXI_ACLK_FREQ_HZ, 100000000: clock frequency, informational only.
- C_S_AXI_DATA_WIDTH, 32: AXI data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 16: AXI address width.
- VIRTUAL_NODES, 100: reservoir delay length and weight-memory depth.
- RESERVOIR_DATA_WIDTH, 32: signed node/sample width.
- RESERVOIR_HISTORY_ADDR_WIDTH, 16: depth exponent of the input and reservoir memories.

One clock; reset is asynchronous and active-low.
- S_AXI_ACLK, in, 1: clock.
- S_AXI_ARESETN, in, 1: asynchronous active-low reset.
- S_AXI_AWADDR, in, ADDR: word address. S_AXI_AWVALID, in, 1. S_AXI_AWREADY, out, 1.
- S_AXI_WDATA, in, 32. S_AXI_WSTRB, in, 4, ignored (full-word writes only). S_AXI_WVALID, in, 1. S_AXI_WREADY, out, 1.
- S_AXI_BRESP, out, 2, always 0. S_AXI_BVALID, out, 1. S_AXI_BREADY, in, 1.
- S_AXI_ARADDR, in, ADDR. S_AXI_ARVALID, in, 1. S_AXI_ARREADY, out, 1.
- S_AXI_RDATA, out, 32. S_AXI_RRESP, out, 2, always 0. S_AXI_RVALID, out, 1. S_AXI_RREADY, in, 1.
- busy, out, 1: high from launch until outputs are valid.

## Operation
- Address map (word addresses):
  - 0x0000 CTRL: bit0 START (write 1 launches; reads 0); bits[5:4] MEMSEL (0 input, 1 reservoir, 2 weight, 3 output); bits[15:8] PAGE.
  - 0x0004 DEBUG.
  - 0x0008 NUM_INIT_SAMPLES, 0x000C NUM_TRAIN_SAMPLES, 0x0010 NUM_TEST_SAMPLES.
  - 0x0014 NUM_STEPS_PER_SAMPLE.
  - 0x0018 NUM_INIT_STEPS, 0x001C NUM_TRAIN_STEPS, 0x0020 NUM_TEST_STEPS.
- Window 0x0100–0x01FF accesses the selected memory at index {PAGE, addr[7:0]}. Weight and output memories ignore PAGE. Unmapped addresses read 0 and ignore writes.
- Window writes while busy are ignored. Window reads while busy return 0.
- Reservoir step k (global step counter starting at 0):
  - x[k] = sat32(in[k] + (x[k−VIRTUAL_NODES] >>> 1)); x[j<0] = 0.
  - x[k] is stored at reservoir[k].
- Run sequence: INIT (NUM_INIT_STEPS steps), then TRAIN (NUM_TRAIN_STEPS), then TEST (NUM_TEST_STEPS), then READOUT, then back to IDLE.
- READOUT, for each s < NUM_TEST_SAMPLES:
  - y[s] = (Σ_{n<NUM_STEPS_PER_SAMPLE} w[n]·x[base + s·NUM_STEPS_PER_SAMPLE + n])[47:16], where base = NUM_INIT_STEPS + NUM_TRAIN_STEPS.
  - Products are 64-bit signed; the accumulator is 64-bit and wraps.
  - y[s] is written to output[s].
- A phase with a zero count is skipped. Steps beyond memory depth wrap the index.

## Timing
- Reset values: all *READY/*VALID low, RDATA 0, busy 0, all registers 0, FSM in IDLE. Memory contents are undefined.
- Write channel:
  - AWREADY and WREADY pulse together for one cycle, on the cycle after AWVALID & WVALID are seen with AWREADY low.
  - The write takes effect at that handshake edge.
  - BVALID rises at the same edge and stays high until BREADY is sampled high or the next write is accepted.
  - Write acceptance never waits on BVALID.
- Read channel:
  - ARREADY pulses for one cycle when ARVALID is high, ARREADY is low and RVALID is low.
  - RVALID and RDATA are driven 2 cycles after the AR handshake (synchronous RAM read) and held until RREADY is sampled high.
- START: busy rises on the cycle after the START write.
- Each reservoir step takes 2 cycles (read in[k] and x[k−N]; write x[k]). Each readout MAC takes 1 cycle, plus 2 cycles per sample to store.
- busy falls on the cycle the last output write completes.
- START while busy is ignored. Count registers are sampled at launch.
- Reset mid-run returns the FSM to IDLE immediately with busy low.

## Configuration
- DFR_DEBUG_EN defined: DEBUG (0x0004) reads {FSM state[3:0], 12'b0, step counter[15:0]}.
- DFR_DEBUG_EN undefined: DEBUG reads 0 and writes are ignored.

## Test plan
- Reset, then read every register -> 0. Write 100 to 0x0008 and read it back -> 100. Write to 0x0024 -> reads 0.
- CTRL=0x20; write weights w[0..3]=65536 to 0x0100–0x0103; CTRL=0x20, read 0x0101 -> 65536. Window read while busy -> 0.
- Paging: CTRL=0x0100 (input, page 1), write 0x0105=7; CTRL=0x0000, read 0x0105 -> not 7; CTRL=0x0100, read 0x0105 -> 7.
- Mini run with VIRTUAL_NODES=4, steps/sample 4, init 0, train 0, test 2 samples (8 steps), in[k]=65536 for all k, w[n]=65536:
  - Launch -> busy rises, then falls.
  - x = 65536 ×4, then 98304 ×4.
  - Output mem (CTRL=0x30): y[0]=262144, y[1]=393216.
- Saturation: in[k]=0x7FFFFFFF for all k -> x[4..] = 0x7FFFFFFF, no wrap.
- Write with BREADY held low across two back-to-back writes -> both writes land. Assert reset mid-run -> busy low at once; a new START completes normally.
